serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. It sequences the existing single-bit full_adder cell over two WIDTH-bit operands, LSB first, one bit per clock.
- Carry is held in a register between bits.
- Start/busy/done handshake toward the requester.
- Provides an area-minimal multi-bit add built on the shared full_adder datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous, active-high reset
- start  input   1      request to begin an add; sampled only in IDLE or DONE
- a      input   WIDTH  operand A; captured on the accepted start edge
- b      input   WIDTH  operand B; captured on the accepted start edge
- cin    input   1      initial carry-in; captured on the accepted start edge
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse when sum/cout become valid
- sum    output  WIDTH  result of a+b+cin mod 2^WIDTH; registered
- cout   output  1      carry out of bit WIDTH-1; registered

Behaviour:
- Reset (rst=1, asynchronous, any state):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry register and bit counter all cleared.
  - Reset mid-RUN aborts the operation with no done pulse.
- FSM states IDLE, RUN, DONE:
  - IDLE: start=1 captures a→a_sh, b→b_sh, cin→carry; cnt=0; next RUN. start=0 stays IDLE.
  - RUN, each edge:
    - full_adder inputs are a_sh[0], b_sh[0], carry.
    - fa.sum shifts into acc MSB (acc shifts right).
    - carry takes fa.carry.
    - a_sh and b_sh shift right.
    - cnt increments.
    - On the edge where cnt==WIDTH-1: sum←{fa.sum, acc[WIDTH-1:1]}, cout←fa.carry, next DONE.
  - DONE: done=1 for exactly this one cycle. start=1 behaves as in IDLE and goes directly to RUN (back-to-back operation). start=0 goes to IDLE.
- Latency: start sampled at edge k gives done=1 during the cycle after edge k+WIDTH, i.e. WIDTH+1 edges. Throughput is one add per WIDTH+1 cycles with back-to-back starts.
- busy=1 exactly in RUN, for WIDTH cycles. busy and done are never high together.
- start while busy: ignored. Operands are not re-captured and the in-flight add is unaffected.
- a, b, cin may change freely after the capture edge.
- sum/cout hold the last completed result through IDLE and the next RUN. They update only on the completing edge.
- Counter width is clog2(WIDTH). Wrap-around is not possible because the FSM leaves RUN at WIDTH-1.
- Arithmetic: {cout,sum} == a + b + cin, computed at full WIDTH+1 bits.

Decomposition:
- Package serial_add_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH constant
  - counter-width function clog2
- One sub-module: the existing full_adder (ports a, b, cin, sum, carry), instantiated once as the sole arithmetic element.
- The controller contains no other adder logic.

Test Plan:
- Reset then 0x00+0x00, cin=0, start one cycle → busy high 8 cycles, done pulse at edge 9, sum=0x00, cout=0.
- 0x3C+0x42, cin=0 → sum=0x7E, cout=0. Then 0xFF+0x01, cin=0 → sum=0x00, cout=1.
- 0xA5+0x5A, cin=1 → sum=0x00, cout=1. Change a/b to 0xFF on the edge after capture → result unchanged.
- Hold start=1 continuously with 0x10+0x20, cin=0:
  - start pulses during RUN are ignored (busy stays 8 cycles)
  - DONE re-launches immediately
  - done pulses every 9 cycles, sum=0x30 each time
- Assert rst asynchronously mid-RUN (between edges, cycle 4) → busy/done/sum/cout drop to 0 immediately. No done pulse follows. A subsequent start of 0x01+0x01 yields sum=0x02.
- Random regression (1000 ops, WIDTH=8 and WIDTH=13) → {cout,sum}==a+b+cin. done appears exactly WIDTH+1 edges after each accepted start.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// Imported by the controller and its testbench.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic element used by the
// serial add controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks one full_adder over two WIDTH-bit
// operands, LSB first, one bit per clock, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; last result held on sum/cout
// RUN   | one operand bit added per clock, busy high
// DONE  | result valid, done high for this one cycle; start relaunches
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] acc_shift;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  // The accumulator keeps only the WIDTH-1 bits already produced; the new
  // bit enters at the top and the full word is complete on the last edge.
  assign acc_shift = {fa_sum, acc_q};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        acc_d   = acc_shift[WIDTH-1:1];
        carry_d = fa_carry;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (cnt_q == CNT_LAST) begin
          sum_d   = acc_shift;
          cout_d  = fa_carry;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=13.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start13, cin13, busy13, done13, cout13;
  logic [12:0] a13, b13, sum13;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One add on the 8-bit instance: launch, time done, compare result.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input bit scramble);
    logic [8:0] exp;
    int lat, bcnt;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    start8 = 1'b0;
    if (scramble) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = ~c; end
    chk({tag, " busy_after_start"}, 64'(busy8), 64'd1);
    lat = 0; bcnt = 1;
    while (lat < 20 && done8 !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
      if (busy8 === 1'b1) bcnt++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd8);
    chk({tag, " busy_cycles"}, 64'(bcnt), 64'd8);
    chk({tag, " busy_with_done"}, 64'(busy8), 64'd0);
    chk({tag, " sum"}, 64'(sum8), 64'(exp[7:0]));
    chk({tag, " cout"}, 64'(cout8), 64'(exp[8]));
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 64'(done8), 64'd0);
  endtask

  task automatic run13(input string tag, input logic [12:0] a, input logic [12:0] b,
                       input logic c);
    logic [13:0] exp;
    int lat;
    exp = {1'b0, a} + {1'b0, b} + {13'd0, c};
    start13 = 1'b1; a13 = a; b13 = b; cin13 = c;
    @(posedge clk); #1;
    start13 = 1'b0;
    a13 = ~a; b13 = ~b; cin13 = ~c;
    lat = 0;
    while (lat < 30 && done13 !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd13);
    chk({tag, " sum_cout"}, 64'({cout13, sum13}), 64'(exp));
  endtask

  initial begin
    int idx, bcnt, npulse, extra;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy8", 64'(busy8), 64'd0);
    chk("reset done8", 64'(done8), 64'd0);
    chk("reset sum8", 64'(sum8), 64'd0);
    chk("reset cout8", 64'(cout8), 64'd0);
    chk("reset sum13", 64'({cout13, sum13, busy13, done13}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run8("zero", 8'h00, 8'h00, 1'b0, 1'b0);
    run8("3c_42", 8'h3C, 8'h42, 1'b0, 1'b0);
    run8("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run8("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 1'b1);

    // start held high: expect a relaunch straight out of DONE every 9 edges
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(posedge clk); #1;
    idx = 0; bcnt = 1; npulse = 0;
    while (idx < 30) begin
      @(posedge clk); #1;
      idx++;
      if (busy8 === 1'b1) bcnt++;
      if (done8 === 1'b1) begin
        chk("hold done_edge", 64'(idx), 64'(8 + 9 * npulse));
        chk("hold sum", 64'(sum8), 64'h30);
        chk("hold busy_cycles", 64'(bcnt), 64'd8);
        bcnt = 0;
        npulse++;
      end
    end
    chk("hold pulse_count", 64'(npulse), 64'd3);
    start8 = 1'b0;
    idx = 0;
    while (idx < 20 && done8 !== 1'b1) begin
      @(posedge clk); #1;
      idx++;
    end
    chk("hold drain", 64'(done8), 64'd1);
    @(posedge clk); #1;

    // asynchronous reset in the middle of a run
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst sum", 64'(sum8), 64'h30);
    rst = 1'b1;
    #1;
    chk("async_rst busy", 64'(busy8), 64'd0);
    chk("async_rst done", 64'(done8), 64'd0);
    chk("async_rst sum", 64'(sum8), 64'd0);
    chk("async_rst cout", 64'(cout8), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) extra++;
    end
    chk("after_rst no_activity", 64'(extra), 64'd0);
    run8("01_01", 8'h01, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++)
      run8("rand8", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b1);
    run13("max13", 13'h1FFF, 13'h1FFF, 1'b1);
    for (int i = 0; i < 1000; i++)
      run13("rand13", 13'($urandom_range(0, 8191)), 13'($urandom_range(0, 8191)),
            1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
